unified_mem_arbiter: RTL and testbench
======================================

Name: unified_mem_arbiter

Overview:
Shares one single-ported, fixed-latency SRAM between the instruction-fetch (IF) port and the data-memory (MEM) stage port of the 5-stage pipeline.
Runs a grant FSM with a cycle-wait counter, returns ready pulses and registered read data, and produces the stall levels the pipeline freeze logic ORs with hazard_detected.
MEM wins simultaneous requests because it belongs to the older instruction.
A granted access is never preempted.

Parameters:
ADDR_W, 18, SRAM word-address width
DATA_W, 32, data width
WAIT_CYCLES, 4, SRAM access cycles per transfer; legal range 1..15

Ports:
clk  in  1  clock, rising edge
rst  in  1  asynchronous, active-low reset
if_req  in  1  IF read request; level, held until if_ready
if_addr  in  ADDR_W  IF address; stable while if_req is high
if_rdata  out  DATA_W  IF read data, registered
if_ready  out  1  one-cycle pulse: IF access complete
mem_req  in  1  MEM request; level, held until mem_ready
mem_we  in  1  1 = write, 0 = read; qualified by mem_req
mem_addr  in  ADDR_W  MEM address
mem_wdata  in  DATA_W  MEM write data
mem_rdata  out  DATA_W  MEM read data, registered
mem_ready  out  1  one-cycle pulse: MEM access complete
if_stall  out  1  if_req & ~if_ready (combinational)
mem_stall  out  1  mem_req & ~mem_ready (combinational)
sram_addr  out  ADDR_W  SRAM address, registered at grant
sram_wdata  out  DATA_W  SRAM write data, registered at grant
sram_we  out  1  SRAM write enable, active-high
sram_oe  out  1  SRAM output enable, active-high
sram_rdata  in  DATA_W  SRAM read data

Behaviour:
- FSM states: IDLE, BUSY, DONE. Register owner: 0 = IF, 1 = MEM.
- IDLE:
  - mem_req=1: grant MEM.
  - else if_req=1: grant IF.
  - else stay in IDLE.
  - On grant: latch addr/wdata/we into the sram_* registers, set owner, set wait_cnt=WAIT_CYCLES-1, go to BUSY.
- BUSY:
  - Drive sram_oe=~we_latched and sram_we=we_latched for every BUSY cycle.
  - When wait_cnt==0: on a read, capture sram_rdata into the owner's rdata register; go to DONE.
  - Otherwise decrement wait_cnt.
- DONE:
  - Pulse the owner's ready for exactly one cycle.
  - sram_we=0, sram_oe=0.
  - Always return to IDLE.
- Latency: request seen in IDLE at cycle t gives ready in cycle t+WAIT_CYCLES+1.
- Back-to-back: IDLE re-arbitrates in the cycle after DONE. Minimum request-to-request spacing is WAIT_CYCLES+2.
- Requester rule: req must still be high in the DONE cycle. A req still high in the following IDLE cycle counts as a new request.
- Request dropped during BUSY: protocol violation. The access still completes and ready still pulses; the bench flags it as an error.
- Writes leave mem_rdata unchanged.
- if_rdata/mem_rdata hold their last captured value until that port's next read completes.
- Both requests held continuously: MEM is served repeatedly and IF starves. This is legal because mem_stall freezes the pipeline, so the IF starvation does no harm.
- Reset, asynchronous at any time including mid-BUSY:
  - State goes to IDLE, wait_cnt=0, owner=0.
  - All ready, sram_we, sram_oe go to 0; sram_addr and sram_wdata go to 0.
  - if_rdata and mem_rdata go to 0.
  - The interrupted access is abandoned and no ready pulse is issued.
- wait_cnt width: 4 bits. WAIT_CYCLES=1 gives one BUSY cycle.

Optional Feature:
MEM_ARB_PERF_CNT_EN
- Defined:
  - Adds outputs if_wait_cnt[31:0] and mem_wait_cnt[31:0].
  - Each counter increments on every cycle its *_stall is 1. It wraps at 2^32 and resets to 0.
- Undefined: the ports and the counter logic are absent. Functional behaviour is identical in both builds.

Decomposition:
- defines.v gets:
  - ARB_STATE_LEN=2, with `ARB_IDLE=0, `ARB_BUSY=1, `ARB_DONE=2;
  - `ARB_OWNER_IF=0 and `ARB_OWNER_MEM=1;
  - `SRAM_ADDR_LEN=18.
- One sub-module, mem_wait_counter: load, decrement and zero flag. It is reusable by a later cache-fill controller.

Test Plan:
- WAIT_CYCLES=4; if_req with if_addr=0x00010 and sram_rdata=0xDEADBEEF in the final BUSY cycle -> if_ready high exactly in cycle t+5, if_rdata=0xDEADBEEF, sram_oe high 4 cycles, sram_we never high.
- if_req and mem_req (read, 0x00200) raised in the same cycle -> MEM granted first, mem_ready at t+5. IF granted at t+6, if_ready at t+11. if_stall stays high t..t+10.
- mem_req, mem_we=1, addr 0x3FFFF, wdata 0x12345678 -> sram_we high 4 cycles with sram_addr=0x3FFFF and sram_wdata=0x12345678. mem_rdata unchanged; mem_ready at t+5.
- rst driven low during the 2nd BUSY cycle of an IF read -> asynchronous clear of all outputs with no ready pulse. After release, a held if_req restarts a full 5-cycle access.
- WAIT_CYCLES=1 with back-to-back IF reads held high -> ready every 3 cycles, each if_rdata matching its access.
- MEM_ARB_PERF_CNT_EN defined, the scenario-2 sequence -> if_wait_cnt=11, mem_wait_cnt=5.

Source files
------------

// File: rtl/unified_mem_arbiter_pkg.sv
// Shared types for the unified IF/MEM SRAM arbiter: FSM states, owner encoding,
// and the wait-counter load helper.
package unified_mem_arbiter_pkg;

    localparam int ARB_STATE_LEN = 2;
    localparam int SRAM_ADDR_LEN = 18;
    localparam int WAIT_CNT_W    = 4;

    typedef enum logic [ARB_STATE_LEN-1:0] {
        ARB_IDLE = 2'd0,
        ARB_BUSY = 2'd1,
        ARB_DONE = 2'd2
    } arb_state_e;

    typedef enum logic {
        ARB_OWNER_IF  = 1'b0,
        ARB_OWNER_MEM = 1'b1
    } arb_owner_e;

    // BUSY lasts wait_cnt+1 cycles, so an access of N cycles loads N-1.
    function automatic logic [WAIT_CNT_W-1:0] wait_load(input int cycles);
        return WAIT_CNT_W'(cycles - 1);
    endfunction

endpackage

// File: rtl/unified_mem_arbiter_if.sv
// Pipeline-side request ports and SRAM-side pins of the unified memory arbiter.
// slave = arbiter view; master = pipeline + SRAM view.
interface unified_mem_arbiter_if #(
    parameter int ADDR_W = 18,
    parameter int DATA_W = 32
);
    logic              if_req;
    logic [ADDR_W-1:0] if_addr;
    logic [DATA_W-1:0] if_rdata;
    logic              if_ready;
    logic              if_stall;
    logic              mem_req;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic [DATA_W-1:0] mem_rdata;
    logic              mem_ready;
    logic              mem_stall;
    logic [ADDR_W-1:0] sram_addr;
    logic [DATA_W-1:0] sram_wdata;
    logic              sram_we;
    logic              sram_oe;
    logic [DATA_W-1:0] sram_rdata;

    modport slave (
        input  if_req, if_addr, mem_req, mem_we, mem_addr, mem_wdata, sram_rdata,
        output if_rdata, if_ready, if_stall, mem_rdata, mem_ready, mem_stall,
               sram_addr, sram_wdata, sram_we, sram_oe
    );

    modport master (
        output if_req, if_addr, mem_req, mem_we, mem_addr, mem_wdata, sram_rdata,
        input  if_rdata, if_ready, if_stall, mem_rdata, mem_ready, mem_stall,
               sram_addr, sram_wdata, sram_we, sram_oe
    );

endinterface

// File: rtl/unified_mem_arbiter_wait_counter.sv
// Loadable down-counter with zero flag; also intended for the cache-fill controller.
module mem_wait_counter #(
    parameter int W = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         load,
    input  logic [W-1:0] load_val,
    input  logic         dec,
    output logic [W-1:0] cnt,
    output logic         zero
);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst)
            cnt <= '0;
        else if (load)
            cnt <= load_val;
        else if (dec && cnt != '0)
            cnt <= cnt - 1'b1;
    end

    assign zero = (cnt == '0);

endmodule

// File: rtl/unified_mem_arbiter.sv
// Single-ported fixed-latency SRAM shared by IF and MEM; MEM wins ties, grants are
// never preempted. Optional stall counters under MEM_ARB_PERF_CNT_EN.
module unified_mem_arbiter
    import unified_mem_arbiter_pkg::*;
#(
    parameter int ADDR_W      = SRAM_ADDR_LEN,
    parameter int DATA_W      = 32,
    parameter int WAIT_CYCLES = 4
) (
    input  logic                clk,
    input  logic                rst,
    unified_mem_arbiter_if.slave bus
`ifdef MEM_ARB_PERF_CNT_EN
    ,
    output logic [31:0]         if_wait_cnt,
    output logic [31:0]         mem_wait_cnt
`endif
);

    arb_state_e            state;
    arb_owner_e            owner;
    logic                  we_latched;
    logic                  cnt_load;
    logic                  cnt_dec;
    logic                  cnt_zero;
    logic [WAIT_CNT_W-1:0] wait_cnt;

    assign cnt_load = (state == ARB_IDLE) && (bus.mem_req || bus.if_req);
    assign cnt_dec  = (state == ARB_BUSY) && !cnt_zero;

    mem_wait_counter #(.W(WAIT_CNT_W)) u_wait (
        .clk      (clk),
        .rst      (rst),
        .load     (cnt_load),
        .load_val (wait_load(WAIT_CYCLES)),
        .dec      (cnt_dec),
        .cnt      (wait_cnt),
        .zero     (cnt_zero)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state          <= ARB_IDLE;
            owner          <= ARB_OWNER_IF;
            we_latched     <= 1'b0;
            bus.sram_addr  <= {ADDR_W{1'b0}};
            bus.sram_wdata <= {DATA_W{1'b0}};
            bus.sram_we    <= 1'b0;
            bus.sram_oe    <= 1'b0;
            bus.if_ready   <= 1'b0;
            bus.mem_ready  <= 1'b0;
            bus.if_rdata   <= {DATA_W{1'b0}};
            bus.mem_rdata  <= {DATA_W{1'b0}};
        end else begin
            case (state)
                ARB_IDLE: begin
                    // MEM belongs to the older instruction, so it wins ties.
                    if (bus.mem_req) begin
                        owner          <= ARB_OWNER_MEM;
                        we_latched     <= bus.mem_we;
                        bus.sram_addr  <= bus.mem_addr;
                        bus.sram_wdata <= bus.mem_wdata;
                        bus.sram_we    <= bus.mem_we;
                        bus.sram_oe    <= ~bus.mem_we;
                        state          <= ARB_BUSY;
                    end else if (bus.if_req) begin
                        owner         <= ARB_OWNER_IF;
                        we_latched    <= 1'b0;
                        bus.sram_addr <= bus.if_addr;
                        bus.sram_we   <= 1'b0;
                        bus.sram_oe   <= 1'b1;
                        state         <= ARB_BUSY;
                    end
                end
                ARB_BUSY: begin
                    if (cnt_zero) begin
                        bus.sram_we <= 1'b0;
                        bus.sram_oe <= 1'b0;
                        if (owner == ARB_OWNER_MEM) begin
                            if (!we_latched) bus.mem_rdata <= bus.sram_rdata;
                            bus.mem_ready <= 1'b1;
                        end else begin
                            bus.if_rdata <= bus.sram_rdata;
                            bus.if_ready <= 1'b1;
                        end
                        state <= ARB_DONE;
                    end
                end
                ARB_DONE: begin
                    bus.if_ready  <= 1'b0;
                    bus.mem_ready <= 1'b0;
                    state         <= ARB_IDLE;
                end
                default: state <= ARB_IDLE;
            endcase
        end
    end

    assign bus.if_stall  = bus.if_req  & ~bus.if_ready;
    assign bus.mem_stall = bus.mem_req & ~bus.mem_ready;

`ifdef MEM_ARB_PERF_CNT_EN
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            if_wait_cnt  <= 32'd0;
            mem_wait_cnt <= 32'd0;
        end else begin
            if (bus.if_stall)  if_wait_cnt  <= if_wait_cnt + 32'd1;
            if (bus.mem_stall) mem_wait_cnt <= mem_wait_cnt + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_unified_mem_arbiter.sv
// Self-checking bench: directed scenarios plus randomized traffic against a
// transaction-level arbitration model; two instances (4-cycle and 1-cycle SRAM).
module tb_unified_mem_arbiter;

    localparam int W4 = 4;

    logic clk = 1'b0;
    logic rst4 = 1'b0;
    logic rst1 = 1'b0;
    int checks = 0;
    int errors = 0;
    logic [31:0] last_mem_rd;

    always #5 clk = ~clk;

    unified_mem_arbiter_if #(.ADDR_W(18), .DATA_W(32)) b4 ();
    unified_mem_arbiter_if #(.ADDR_W(18), .DATA_W(32)) b1 ();

`ifdef MEM_ARB_PERF_CNT_EN
    logic [31:0] ifw4, memw4, ifw1, memw1;
`endif

    unified_mem_arbiter #(.ADDR_W(18), .DATA_W(32), .WAIT_CYCLES(4)) dut4 (
        .clk (clk),
        .rst (rst4),
        .bus (b4)
`ifdef MEM_ARB_PERF_CNT_EN
        ,
        .if_wait_cnt  (ifw4),
        .mem_wait_cnt (memw4)
`endif
    );

    unified_mem_arbiter #(.ADDR_W(18), .DATA_W(32), .WAIT_CYCLES(1)) dut1 (
        .clk (clk),
        .rst (rst1),
        .bus (b1)
`ifdef MEM_ARB_PERF_CNT_EN
        ,
        .if_wait_cnt  (ifw1),
        .mem_wait_cnt (memw1)
`endif
    );

    task automatic clear_inputs();
        b4.if_req = 0; b4.if_addr = '0; b4.mem_req = 0; b4.mem_we = 0;
        b4.mem_addr = '0; b4.mem_wdata = '0; b4.sram_rdata = '0;
        b1.if_req = 0; b1.if_addr = '0; b1.mem_req = 0; b1.mem_we = 0;
        b1.mem_addr = '0; b1.mem_wdata = '0; b1.sram_rdata = '0;
    endtask

    task automatic test_reset();
        clear_inputs();
        rst4 = 0; rst1 = 0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        checks++;
        if ({b4.if_ready, b4.mem_ready, b4.sram_we, b4.sram_oe, b4.if_stall, b4.mem_stall} !== 6'b0) begin
            errors++; $display("FAIL reset_ctrl got %b want 000000",
                {b4.if_ready, b4.mem_ready, b4.sram_we, b4.sram_oe, b4.if_stall, b4.mem_stall});
        end
        checks++;
        if ({b4.sram_addr, b4.sram_wdata, b4.if_rdata, b4.mem_rdata} !== '0) begin
            errors++; $display("FAIL reset_data got addr %h wd %h ird %h mrd %h want 0",
                b4.sram_addr, b4.sram_wdata, b4.if_rdata, b4.mem_rdata);
        end
        checks++;
        if ({b1.if_ready, b1.sram_oe, b1.if_rdata} !== '0) begin
            errors++; $display("FAIL reset_dut1 got rdy %b oe %b ird %h want 0", b1.if_ready, b1.sram_oe, b1.if_rdata);
        end
        rst4 = 1; rst1 = 1;
        @(posedge clk); #1;
    endtask

    task automatic test_if_read();
        int oe_cnt = 0;
        int we_cnt = 0;
        b4.if_addr = 18'h00010; b4.if_req = 1; b4.sram_rdata = $urandom;
        for (int k = 0; k <= 7; k++) begin
            @(negedge clk);
            oe_cnt += int'(b4.sram_oe);
            we_cnt += int'(b4.sram_we);
            checks++;
            if (b4.if_ready !== (k == 5)) begin
                errors++; $display("FAIL if_read_ready k=%0d got %b want %b", k, b4.if_ready, k == 5);
            end
            if (k >= 1 && k <= 4) begin
                checks++;
                if (b4.sram_addr !== 18'h00010) begin
                    errors++; $display("FAIL if_read_addr k=%0d got %h want 00010", k, b4.sram_addr);
                end
            end
            if (k == 5) begin
                checks++;
                if (b4.if_rdata !== 32'hDEADBEEF) begin
                    errors++; $display("FAIL if_read_data got %h want deadbeef", b4.if_rdata);
                end
            end
            @(posedge clk); #1;
            b4.sram_rdata = (k + 1 == 4) ? 32'hDEADBEEF : $urandom;
            if (k == 5) b4.if_req = 0;
        end
        checks++;
        if (oe_cnt != 4 || we_cnt != 0) begin
            errors++; $display("FAIL if_read_pins got oe %0d we %0d want oe 4 we 0", oe_cnt, we_cnt);
        end
    endtask

    task automatic test_arbitration();
        logic [31:0] rd [0:15];
`ifdef MEM_ARB_PERF_CNT_EN
        logic [31:0] if_snap, mem_snap;
        if_snap = ifw4; mem_snap = memw4;
`endif
        b4.if_addr = 18'h00055; b4.if_req = 1;
        b4.mem_addr = 18'h00200; b4.mem_we = 0; b4.mem_req = 1;
        b4.sram_rdata = $urandom;
        for (int k = 0; k <= 12; k++) begin
            @(negedge clk);
            rd[k] = b4.sram_rdata;
            checks++;
            if (b4.mem_ready !== (k == 5) || b4.if_ready !== (k == 11)) begin
                errors++; $display("FAIL arb_ready k=%0d got mem %b if %b want mem %b if %b",
                    k, b4.mem_ready, b4.if_ready, k == 5, k == 11);
            end
            checks++;
            if (b4.if_stall !== (k <= 10) || b4.mem_stall !== (k <= 4)) begin
                errors++; $display("FAIL arb_stall k=%0d got if %b mem %b want if %b mem %b",
                    k, b4.if_stall, b4.mem_stall, k <= 10, k <= 4);
            end
            if ((k >= 1 && k <= 4) || (k >= 7 && k <= 10)) begin
                checks++;
                if (b4.sram_addr !== ((k <= 4) ? 18'h00200 : 18'h00055)) begin
                    errors++; $display("FAIL arb_addr k=%0d got %h", k, b4.sram_addr);
                end
            end
            if (k == 5) begin
                checks++;
                if (b4.mem_rdata !== rd[4]) begin
                    errors++; $display("FAIL arb_mem_data got %h want %h", b4.mem_rdata, rd[4]);
                end
            end
            if (k == 11) begin
                checks++;
                if (b4.if_rdata !== rd[10]) begin
                    errors++; $display("FAIL arb_if_data got %h want %h", b4.if_rdata, rd[10]);
                end
            end
            @(posedge clk); #1;
            b4.sram_rdata = $urandom;
            if (k == 5) b4.mem_req = 0;
            if (k == 11) b4.if_req = 0;
        end
        last_mem_rd = rd[4];
`ifdef MEM_ARB_PERF_CNT_EN
        checks++;
        if (ifw4 - if_snap !== 32'd11 || memw4 - mem_snap !== 32'd5) begin
            errors++; $display("FAIL perf_cnt got if %0d mem %0d want if 11 mem 5", ifw4 - if_snap, memw4 - mem_snap);
        end
`endif
    endtask

    task automatic test_write();
        b4.mem_addr = 18'h3FFFF; b4.mem_wdata = 32'h12345678; b4.mem_we = 1; b4.mem_req = 1;
        for (int k = 0; k <= 6; k++) begin
            @(negedge clk);
            checks++;
            if (b4.mem_ready !== (k == 5)) begin
                errors++; $display("FAIL wr_ready k=%0d got %b want %b", k, b4.mem_ready, k == 5);
            end
            checks++;
            if (k >= 1 && k <= 4) begin
                if ({b4.sram_we, b4.sram_oe} !== 2'b10 || b4.sram_addr !== 18'h3FFFF || b4.sram_wdata !== 32'h12345678) begin
                    errors++; $display("FAIL wr_pins k=%0d got we %b oe %b a %h d %h want 1 0 3ffff 12345678",
                        k, b4.sram_we, b4.sram_oe, b4.sram_addr, b4.sram_wdata);
                end
            end else if (b4.sram_we !== 1'b0) begin
                errors++; $display("FAIL wr_we_idle k=%0d got %b want 0", k, b4.sram_we);
            end
            checks++;
            if (b4.mem_rdata !== last_mem_rd) begin
                errors++; $display("FAIL wr_rdata_hold k=%0d got %h want %h", k, b4.mem_rdata, last_mem_rd);
            end
            @(posedge clk); #1;
            if (k == 5) begin b4.mem_req = 0; b4.mem_we = 0; end
        end
    endtask

    task automatic test_reset_mid_busy();
        logic [31:0] cap = '0;
        b4.if_addr = 18'h00123; b4.if_req = 1;
        @(negedge clk);
        @(posedge clk); #1;
        @(posedge clk); #3;
        rst4 = 0; #1;
        checks++;
        if ({b4.if_ready, b4.mem_ready, b4.sram_we, b4.sram_oe} !== 4'b0 ||
            {b4.sram_addr, b4.sram_wdata, b4.if_rdata, b4.mem_rdata} !== '0) begin
            errors++; $display("FAIL midrst_clear got rdy %b%b we %b oe %b a %h d %h ird %h mrd %h want 0",
                b4.if_ready, b4.mem_ready, b4.sram_we, b4.sram_oe, b4.sram_addr, b4.sram_wdata, b4.if_rdata, b4.mem_rdata);
        end
        repeat (2) begin
            @(negedge clk);
            checks++;
            if (b4.if_ready !== 1'b0 || b4.sram_oe !== 1'b0) begin
                errors++; $display("FAIL midrst_hold got rdy %b oe %b want 0 0", b4.if_ready, b4.sram_oe);
            end
        end
        rst4 = 1;
        @(posedge clk); #1;
        for (int k = 1; k <= 7; k++) begin
            b4.sram_rdata = $urandom;
            @(negedge clk);
            if (k == 4) cap = b4.sram_rdata;
            checks++;
            if (b4.if_ready !== (k == 5) || b4.sram_oe !== (k >= 1 && k <= 4)) begin
                errors++; $display("FAIL midrst_restart k=%0d got rdy %b oe %b want %b %b",
                    k, b4.if_ready, b4.sram_oe, k == 5, k >= 1 && k <= 4);
            end
            if (k == 5) begin
                checks++;
                if (b4.if_rdata !== cap) begin
                    errors++; $display("FAIL midrst_data got %h want %h", b4.if_rdata, cap);
                end
            end
            @(posedge clk); #1;
            if (k == 5) b4.if_req = 0;
        end
    endtask

    task automatic test_back_to_back();
        logic [17:0] cur;
        logic [31:0] cap = '0;
        cur = 18'($urandom);
        b1.if_addr = cur; b1.if_req = 1; b1.sram_rdata = $urandom;
        for (int k = 0; k <= 14; k++) begin
            @(negedge clk);
            checks++;
            if (b1.if_ready !== (k % 3 == 2) || b1.sram_oe !== (k % 3 == 1)) begin
                errors++; $display("FAIL b2b_timing k=%0d got rdy %b oe %b want %b %b",
                    k, b1.if_ready, b1.sram_oe, k % 3 == 2, k % 3 == 1);
            end
            if (k % 3 == 1) begin
                cap = b1.sram_rdata;
                checks++;
                if (b1.sram_addr !== cur) begin
                    errors++; $display("FAIL b2b_addr k=%0d got %h want %h", k, b1.sram_addr, cur);
                end
            end
            if (k % 3 == 2) begin
                checks++;
                if (b1.if_rdata !== cap) begin
                    errors++; $display("FAIL b2b_data k=%0d got %h want %h", k, b1.if_rdata, cap);
                end
            end
            @(posedge clk); #1;
            b1.sram_rdata = $urandom;
            if (k % 3 == 2) begin cur = 18'($urandom); b1.if_addr = cur; end
        end
        b1.if_req = 0;
    endtask

    // Transaction model: an idle arbiter grants MEM over IF, an access granted in
    // cycle g completes in cycle g+W+1 with the data present in cycle g+W, and the
    // next arbitration happens at g+W+2.
    task automatic test_random();
        bit ip = 0, mp = 0, mwe = 0, busy = 0, own_mem = 0, g_we = 0, e_if, e_mem;
        logic [17:0] ia = '0, ma = '0, g_a = '0;
        logic [31:0] md = '0, g_d = '0, cap = '0, exp_if = '0, exp_mem = '0;
        int g = 0, free_at = 0;
        clear_inputs();
        rst4 = 0;
        @(posedge clk);
        @(negedge clk);
        rst4 = 1;
        @(posedge clk); #1;
        for (int c = 0; c < 400; c++) begin
            @(negedge clk);
            e_if  = busy && !own_mem && (c == g + W4 + 1);
            e_mem = busy &&  own_mem && (c == g + W4 + 1);
            checks++;
            if (b4.if_ready !== e_if || b4.mem_ready !== e_mem) begin
                errors++; $display("FAIL rnd_ready c=%0d got if %b mem %b want if %b mem %b",
                    c, b4.if_ready, b4.mem_ready, e_if, e_mem);
            end
            checks++;
            if (b4.if_stall !== (ip && !e_if) || b4.mem_stall !== (mp && !e_mem)) begin
                errors++; $display("FAIL rnd_stall c=%0d got if %b mem %b want if %b mem %b",
                    c, b4.if_stall, b4.mem_stall, ip && !e_if, mp && !e_mem);
            end
            checks++;
            if (busy && c >= g + 1 && c <= g + W4) begin
                if (b4.sram_we !== g_we || b4.sram_oe !== !g_we || b4.sram_addr !== g_a ||
                    (g_we && b4.sram_wdata !== g_d)) begin
                    errors++; $display("FAIL rnd_sram c=%0d got we %b oe %b a %h d %h want %b %b %h %h",
                        c, b4.sram_we, b4.sram_oe, b4.sram_addr, b4.sram_wdata, g_we, !g_we, g_a, g_d);
                end
                if (c == g + W4) cap = b4.sram_rdata;
            end else if (b4.sram_we !== 1'b0 || b4.sram_oe !== 1'b0) begin
                errors++; $display("FAIL rnd_sram_idle c=%0d got we %b oe %b want 0 0", c, b4.sram_we, b4.sram_oe);
            end
            if (e_if)  begin exp_if = cap; ip = 0; busy = 0; end
            if (e_mem) begin if (!g_we) exp_mem = cap; mp = 0; busy = 0; end
            checks++;
            if (b4.if_rdata !== exp_if || b4.mem_rdata !== exp_mem) begin
                errors++; $display("FAIL rnd_rdata c=%0d got if %h mem %h want if %h mem %h",
                    c, b4.if_rdata, b4.mem_rdata, exp_if, exp_mem);
            end
            if (!busy && c >= free_at && (mp || ip)) begin
                busy = 1; g = c; free_at = c + W4 + 2; own_mem = mp;
                g_we = mp ? mwe : 1'b0; g_a = mp ? ma : ia; g_d = md;
            end
            @(posedge clk); #1;
            if (!ip && $urandom_range(2) == 0) begin ip = 1; ia = 18'($urandom); end
            if (!mp && $urandom_range(3) == 0) begin
                mp = 1; mwe = 1'($urandom); ma = 18'($urandom); md = $urandom;
            end
            b4.if_req = ip; b4.if_addr = ia;
            b4.mem_req = mp; b4.mem_we = mwe; b4.mem_addr = ma; b4.mem_wdata = md;
            b4.sram_rdata = $urandom;
        end
        clear_inputs();
    endtask

    initial begin
        test_reset();
        test_if_read();
        test_arbitration();
        test_write();
        test_reset_mid_busy();
        test_back_to_back();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
